// File: rtl/coin_pulse_scheduler.sv
// rtl/coin_pulse_scheduler.sv - round-robin frame-timed active-low coin pulse generator (option: COIN_QUEUE_EN)
module coin_pulse_scheduler #(
    parameter int PULSE_FRAMES = 4,
    parameter int GAP_FRAMES   = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       req1,
    input  logic       req2,
    input  logic       vs,
    output logic       coin1_n,
    output logic       coin2_n,
    output logic       busy,
    output logic [1:0] pend1,
    output logic [1:0] pend2
);

`ifdef COIN_QUEUE_EN
    localparam logic [1:0] DEPTH = 2'd3;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    localparam logic [3:0] PULSE_CNT = 4'(PULSE_FRAMES);
    localparam logic [3:0] GAP_CNT   = 4'(GAP_FRAMES);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t     state, state_d;
    logic [3:0] cnt, cnt_d;
    logic [1:0] pend1_q, pend1_d, pend2_q, pend2_d;
    logic       last2, last2_d;   // 1: coin2 was served last
    logic       chan2, chan2_d;   // 1: the pulse in progress belongs to coin2
    logic       req1_q, req2_q, vs_q;
    logic       ev1, ev2, tick;
    logic       gnt1, gnt2;

    assign ev1  = req1 & ~req1_q;
    assign ev2  = req2 & ~req2_q;
    assign tick = vs & ~vs_q;

    // Pending counter update; a simultaneous event and grant cancel out.
    function automatic logic [1:0] pend_next(input logic [1:0] p, input logic ev, input logic gnt);
        if (ev && !gnt)
            return (p == DEPTH) ? p : p + 2'd1;
        else if (!ev && gnt)
            return p - 2'd1;
        else
            return p;
    endfunction

    // Edge-detect copies start high so held inputs at reset release are ignored.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            req1_q <= 1'b1;
            req2_q <= 1'b1;
            vs_q   <= 1'b1;
        end else begin
            req1_q <= req1;
            req2_q <= req2;
            vs_q   <= vs;
        end
    end

    // State, frame counter, queues and arbitration pointer.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend1_q <= 2'd0;
            pend2_q <= 2'd0;
            last2   <= 1'b1;
            chan2   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
            last2   <= last2_d;
            chan2   <= chan2_d;
        end
    end

    // Grant in IDLE, count frame ticks through PULSE and GAP.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        last2_d = last2;
        chan2_d = chan2;
        gnt1    = 1'b0;
        gnt2    = 1'b0;
        case (state)
            IDLE: begin
                if (pend1_q != 2'd0 && (pend2_q == 2'd0 || last2))
                    gnt1 = 1'b1;
                else if (pend2_q != 2'd0)
                    gnt2 = 1'b1;
                if (gnt1 || gnt2) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_CNT;
                    last2_d = gnt2;
                    chan2_d = gnt2;
                end
            end
            PULSE: begin
                if (tick) begin
                    if (cnt <= 4'd1) begin
                        state_d = GAP;
                        cnt_d   = GAP_CNT;
                    end else begin
                        cnt_d = cnt - 4'd1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (cnt <= 4'd1) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt - 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        pend1_d = pend_next(pend1_q, ev1, gnt1);
        pend2_d = pend_next(pend2_q, ev2, gnt2);
    end

    assign busy    = (state != IDLE);
    assign coin1_n = ~((state == PULSE) && !chan2);
    assign coin2_n = ~((state == PULSE) && chan2);
    assign pend1   = pend1_q & {DEPTH[1], 1'b1};
    assign pend2   = pend2_q & {DEPTH[1], 1'b1};

endmodule

// File: tb/tb_coin_pulse_scheduler.sv
// tb/tb_coin_pulse_scheduler.sv - self-checking bench for coin_pulse_scheduler
module tb_coin_pulse_scheduler;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       req1 = 1'b0;
    logic       req2 = 1'b0;
    logic       vs = 1'b0;
    logic       coin1_n, coin2_n, busy;
    logic [1:0] pend1, pend2;

    int n_checks = 0;
    int n_errors = 0;
    int falls1 = 0, falls2 = 0, overlaps = 0, max_p1 = 0;
    int first_ch = 0;
    logic prev1 = 1'b1, prev2 = 1'b1;

    typedef struct {
        logic       r1, r2, v;
        logic [6:0] exp;   // {coin1_n, coin2_n, busy, pend1, pend2}
    } vec_t;

    vec_t vecs[20];

    coin_pulse_scheduler #(.PULSE_FRAMES(4), .GAP_FRAMES(4)) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .req1   (req1),
        .req2   (req2),
        .vs     (vs),
        .coin1_n(coin1_n),
        .coin2_n(coin2_n),
        .busy   (busy),
        .pend1  (pend1),
        .pend2  (pend2)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input logic r1, input logic r2, input logic v);
        req1 = r1;
        req2 = r2;
        vs   = v;
        @(posedge clk_sys);
        #1;
        if (prev1 && !coin1_n) begin
            falls1++;
            if (first_ch == 0) first_ch = 1;
        end
        if (prev2 && !coin2_n) begin
            falls2++;
            if (first_ch == 0) first_ch = 2;
        end
        if (!coin1_n && !coin2_n) overlaps++;
        if (int'(pend1) > max_p1) max_p1 = int'(pend1);
        prev1 = coin1_n;
        prev2 = coin2_n;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset(input logic r1);
        req1 = r1;
        req2 = 1'b0;
        vs   = 1'b0;
        reset = 1'b1;
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        prev1 = 1'b1;
        prev2 = 1'b1;
        falls1 = 0;
        falls2 = 0;
        overlaps = 0;
        max_p1 = 0;
        first_ch = 0;
    endtask

    task automatic set_vec(input int i, input logic r1, input logic r2, input logic v,
                           input logic c1, input logic c2, input logic b,
                           input logic [1:0] p1, input logic [1:0] p2);
        vecs[i].r1  = r1;
        vecs[i].r2  = r2;
        vecs[i].v   = v;
        vecs[i].exp = {c1, c2, b, p1, p2};
    endtask

    initial begin
        // single coin1 pulse: 4 ticks low, 4 ticks gap, back to idle
        set_vec(0,  0, 0, 0, 1, 1, 0, 2'd0, 2'd0);
        set_vec(1,  1, 0, 0, 1, 1, 0, 2'd1, 2'd0);
        set_vec(2,  1, 0, 0, 0, 1, 1, 2'd0, 2'd0);
        set_vec(3,  0, 0, 0, 0, 1, 1, 2'd0, 2'd0);
        set_vec(4,  0, 0, 1, 0, 1, 1, 2'd0, 2'd0);
        set_vec(5,  0, 0, 1, 0, 1, 1, 2'd0, 2'd0);
        set_vec(6,  0, 0, 0, 0, 1, 1, 2'd0, 2'd0);
        set_vec(7,  0, 0, 1, 0, 1, 1, 2'd0, 2'd0);
        set_vec(8,  0, 0, 0, 0, 1, 1, 2'd0, 2'd0);
        set_vec(9,  0, 0, 1, 0, 1, 1, 2'd0, 2'd0);
        set_vec(10, 0, 0, 0, 0, 1, 1, 2'd0, 2'd0);
        set_vec(11, 0, 0, 1, 1, 1, 1, 2'd0, 2'd0);
        set_vec(12, 0, 0, 0, 1, 1, 1, 2'd0, 2'd0);
        set_vec(13, 0, 0, 1, 1, 1, 1, 2'd0, 2'd0);
        set_vec(14, 0, 0, 0, 1, 1, 1, 2'd0, 2'd0);
        set_vec(15, 0, 0, 1, 1, 1, 1, 2'd0, 2'd0);
        set_vec(16, 0, 0, 0, 1, 1, 1, 2'd0, 2'd0);
        set_vec(17, 0, 0, 1, 1, 1, 1, 2'd0, 2'd0);
        set_vec(18, 0, 0, 0, 1, 1, 1, 2'd0, 2'd0);
        set_vec(19, 0, 0, 1, 1, 1, 0, 2'd0, 2'd0);

        // reset state while reset is held
        #3;
        chk("rst_coin1_n", int'(coin1_n), 1);
        chk("rst_coin2_n", int'(coin2_n), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pend1", int'(pend1), 0);
        chk("rst_pend2", int'(pend2), 0);

        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(vecs[i].r1, vecs[i].r2, vecs[i].v);
            chk($sformatf("vec%0d", i), int'({coin1_n, coin2_n, busy, pend1, pend2}), int'(vecs[i].exp));
        end

        // req1 held through reset release: no event
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("held_falls1", falls1, 0);
        chk("held_pend1", int'(pend1), 0);
        chk("held_coin1_n", int'(coin1_n), 1);

        // simultaneous requests: coin1 first, never overlapping
        do_reset(1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("tie_pend1", int'(pend1), 1);
        chk("tie_pend2", int'(pend2), 1);
        run_frames(20);
        chk("tie_first", first_ch, 1);
        chk("tie_falls1", falls1, 1);
        chk("tie_falls2", falls2, 1);
        chk("tie_overlap", overlaps, 0);
        chk("tie_idle", int'(busy), 0);

        // five req1 edges during one pulse
        do_reset(1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
        run_frames(60);
`ifdef COIN_QUEUE_EN
        chk("sat_max_pend1", max_p1, 3);
        chk("sat_falls1", falls1, 4);
`else
        chk("sat_max_pend1", max_p1, 1);
        chk("sat_falls1", falls1, 2);
`endif
        chk("sat_idle", int'(busy), 0);

        // req2 edge on the coin2 grant cycle
        do_reset(1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        run_frames(7);
        cyc(1'b0, 1'b0, 1'b1);
        chk("same_pre_busy", int'(busy), 0);
        chk("same_pre_pend2", int'(pend2), 1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("same_pend2", int'(pend2), 1);
        chk("same_coin2_n", int'(coin2_n), 0);
        run_frames(20);
        chk("same_falls2", falls2, 2);
        chk("same_overlap", overlaps, 0);

        // asynchronous reset two ticks into a coin1 pulse
        do_reset(1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        run_frames(2);
        chk("arst_pre_coin1_n", int'(coin1_n), 0);
        chk("arst_pre_pend2", int'(pend2), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_coin1_n", int'(coin1_n), 1);
        chk("arst_pend1", int'(pend1), 0);
        chk("arst_pend2", int'(pend2), 0);
        chk("arst_busy", int'(busy), 0);
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        prev1 = coin1_n;
        prev2 = coin2_n;
        falls1 = 0;
        falls2 = 0;
        run_frames(20);
        chk("arst_after_falls1", falls1, 0);
        chk("arst_after_falls2", falls2, 0);
        chk("arst_after_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/coin_pulse_scheduler.md
COIN_PULSE_SCHEDULER -- requirements
Module: coin_pulse_scheduler

Purpose: converts short coin key or joystick presses into frame-timed, non-overlapping active-low coin pulses for the game core. Two requesters (coin1, coin2) share one pulse generator.

Interface
REQ-001 The block SHALL have parameter PULSE_FRAMES, default 4, giving the coin pulse length in vsync rising edges (legal range 1..15).
REQ-002 The block SHALL have parameter GAP_FRAMES, default 4, giving the minimum inactive time between pulses in vsync rising edges (legal range 1..15).
REQ-003 clk_sys  input  1  system clock (24.192 MHz); sole clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req1  input  1  coin1 press level, active-high, synchronous to clk_sys.
REQ-006 req2  input  1  coin2 press level, active-high, synchronous to clk_sys.
REQ-007 vs  input  1  game vertical sync level, active-high, synchronous to clk_sys.
REQ-008 coin1_n  output  1  coin1 to game, active-low.
REQ-009 coin2_n  output  1  coin2 to game, active-low.
REQ-010 busy  output  1  high while in PULSE or GAP.
REQ-011 pend1  output  2  queued coin1 requests.
REQ-012 pend2  output  2  queued coin2 requests.

Function
REQ-013 A request event SHALL be a 0->1 transition of reqN versus its registered copy; holding reqN high SHALL produce exactly one event.
REQ-014 A frame tick SHALL be a 0->1 transition of vs versus its registered copy; one tick per rising edge.
REQ-015 Each request event SHALL increment pendN, saturating at the configured depth (REQ-028/029); events at saturation SHALL be dropped.
REQ-016 The FSM SHALL have the states IDLE, PULSE and GAP.
REQ-017 IDLE: if any pendN != 0, the FSM SHALL grant one channel on that clk_sys cycle, decrement its pendN, load the frame counter with PULSE_FRAMES and enter PULSE.
REQ-018 Arbitration SHALL be round-robin: when both are pending, the channel not served last is granted; with one pending, that channel is granted.
REQ-019 The last-served pointer SHALL update on every grant.
REQ-020 PULSE: the granted coinN_n SHALL be 0 from the cycle after the grant. Each frame tick decrements the counter; the tick that reaches 0 SHALL load GAP_FRAMES and enter GAP, and coinN_n returns to 1 the next cycle.
REQ-021 GAP: both coinN_n SHALL be 1. Each tick decrements the counter; the tick that reaches 0 SHALL enter IDLE.
REQ-022 At most one of coin1_n and coin2_n SHALL be 0 at any time.
REQ-023 A request event and a grant on the same channel in the same cycle SHALL leave pendN unchanged (net +1 -1).
REQ-024 Events arriving during PULSE or GAP SHALL be queued per REQ-015 and never cut short the current pulse or gap.
REQ-025 busy SHALL be 1 exactly when the state is PULSE or GAP.

Reset
REQ-026 While reset is high, the block SHALL immediately (asynchronously) force: state IDLE, coin1_n=1, coin2_n=1, busy=0, pend1=pend2=0, counter=0, last-served=coin2 (so coin1 wins the first tie), and registered req1/req2/vs copies = 1. Consequence: a held key or a high vs at reset release does not generate an event.
REQ-027 Reset asserted mid-pulse SHALL abort the pulse; no pulse resumes after release.

Configuration
REQ-028 With COIN_QUEUE_EN defined: pendN SHALL be a saturating counter with depth 3.
REQ-029 Without COIN_QUEUE_EN: depth SHALL be 1, so pendN is 0 or 1 and bit 1 is tied 0. A second event before the grant is dropped.

Verification
REQ-030 Reset release with req1 held high, then no new edge -> no pulse; coin1_n stays 1; pend1=0.
REQ-031 One req1 edge with defaults -> coin1_n low the cycle after grant, for exactly 4 vs rising edges. This is followed by a 4-tick GAP with busy=1, then IDLE with busy=0.
REQ-032 req1 and req2 edges in the same cycle after reset -> coin1 pulses first, then coin2 after the gap. coin1_n and coin2_n are never low together.
REQ-033 With COIN_QUEUE_EN, five req1 edges during one pulse -> pend1 saturates at 3 and exactly 4 coin1 pulses total are produced. Without the macro, the same stimulus gives pend1 max 1 and 2 pulses.
REQ-034 A req2 edge on the same cycle as the coin2 grant with pend2=1 -> pend2 remains 1 and a further coin2 pulse follows.
REQ-035 Reset asserted 2 ticks into a coin1 pulse -> coin1_n=1 and pend1=pend2=0 without waiting for a clock edge; no pulse after release.
